// File: rtl/frame_packer_pkg.sv
// rtl/frame_packer_pkg.sv - shared types and constants for the frame packer
package frame_packer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAY  = 2'd1,
    TRL  = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_HDR  = 8'hA5;
  localparam logic [7:0] SYNC_TRL  = 8'h5A;
  localparam int         LEN_W_DEF = 20;
  localparam int         CNT_W_DEF = 16;
  localparam int         DATA_W    = 24;

endpackage

// File: rtl/frame_packer_hold2.sv
// rtl/frame_packer_hold2.sv - 2-entry hold FIFO absorbing header/trailer bubbles
module frame_packer_hold2
  import frame_packer_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         ovf
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;
  logic         push_ok;
  logic         pop_ok;

  // A push into a full buffer is lost even if a pop frees a slot this cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push_ok) wp <= ~wp;
      if (pop_ok)  rp <= ~rp;
      cnt <= cnt + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

  assign dout  = mem[rp];
  assign empty = (cnt == 2'd0);
  assign full  = (cnt == 2'd2);
  assign ovf   = push && full;

endmodule

// File: rtl/frame_packer.sv
// rtl/frame_packer.sv - frames 24-bit words with header, optional checksum trailer, whole-frame drop
// Trailer and checksum are built only with FRAME_PACKER_TRAILER_EN defined.
module frame_packer
  import frame_packer_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [23:0]       din,
  input  logic              din_valid,
  input  logic [LEN_W-1:0]  frame_words,
  input  logic              down_full,
  input  logic              down_prog_full,
  output logic [23:0]       dout,
  output logic              dout_wr,
  output logic [CNT_W-1:0]  frame_no,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              err_ovf,
  output logic              err_skid,
  output logic              in_frame
);

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   rem;
  logic [23:0]        head;
  logic               empty;
  logic               full;
  logic               skid_ovf;
  logic               last;
  logic               start_ok;
  logic               busy_dn;

  logic               pop;
  logic               wr_nxt;
  logic [23:0]        dout_nxt;
  logic               start;
  logic               inc_drop;
  logic               set_ovf;
  logic               dec_rem;
  logic               add_csum;

`ifdef FRAME_PACKER_TRAILER_EN
  logic [CNT_W-1:0]   csum;
`endif

  frame_packer_hold2 #(.W(24)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .push  (din_valid),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .ovf   (skid_ovf)
  );

  assign last     = (rem == LEN_W'(1));
  assign start_ok = en && (frame_words != '0);
  assign busy_dn  = down_prog_full || down_full;
  assign in_frame = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!empty && start_ok) state_nxt = busy_dn ? DROP : PAY;
      PAY: begin
        if (!empty) begin
          if (down_full) begin
            state_nxt = last ? IDLE : DROP;
          end else if (last) begin
`ifdef FRAME_PACKER_TRAILER_EN
            state_nxt = TRL;
`else
            state_nxt = IDLE;
`endif
          end
        end
      end
      TRL:  state_nxt = IDLE;
      DROP: if (!empty && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    wr_nxt   = 1'b0;
    dout_nxt = head;
    start    = 1'b0;
    inc_drop = 1'b0;
    set_ovf  = 1'b0;
    dec_rem  = 1'b0;
    add_csum = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (!start_ok) begin
            pop = 1'b1;
          end else begin
            // The frame-start word stays queued; PAY/DROP consume it.
            start = 1'b1;
            if (busy_dn) begin
              inc_drop = 1'b1;
            end else begin
              wr_nxt   = 1'b1;
              dout_nxt = 24'({SYNC_HDR, frame_no});
            end
          end
        end
      end
      PAY: begin
        if (!empty) begin
          pop     = 1'b1;
          dec_rem = 1'b1;
          if (down_full) begin
            set_ovf = 1'b1;
          end else begin
            wr_nxt   = 1'b1;
            add_csum = 1'b1;
          end
        end
      end
      TRL: begin
`ifdef FRAME_PACKER_TRAILER_EN
        if (down_full) begin
          set_ovf = 1'b1;
        end else begin
          wr_nxt   = 1'b1;
          dout_nxt = 24'({SYNC_TRL, csum});
        end
`endif
      end
      DROP: begin
        if (!empty) begin
          pop     = 1'b1;
          dec_rem = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_wr  <= 1'b0;
      rem      <= '0;
      frame_no <= '0;
      drop_cnt <= '0;
      err_ovf  <= 1'b0;
      err_skid <= 1'b0;
    end else begin
      dout_wr <= wr_nxt;
      if (wr_nxt) dout <= dout_nxt;
      if (start) rem <= frame_words;
      else if (dec_rem && rem != '0) rem <= rem - LEN_W'(1);
      if (start) frame_no <= frame_no + CNT_W'(1);
      if (inc_drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      if (set_ovf)  err_ovf  <= 1'b1;
      if (skid_ovf) err_skid <= 1'b1;
    end
  end

`ifdef FRAME_PACKER_TRAILER_EN
  always_ff @(posedge clk) begin
    if (rst || start) csum <= '0;
    else if (add_csum) csum <= csum + CNT_W'(head[15:0]);
  end
`endif

endmodule
